// File: rtl/if_stage_pkg.sv
// Shared fetch-stage configuration: widths, NOP encoding, FSM states, IF/ID payload.
package if_stage_pkg;

    localparam int unsigned ADDRESS_LEN = 8;
    localparam int unsigned WORD_LEN    = 32;
    localparam int unsigned CNT_LEN     = 32;

    localparam logic [WORD_LEN-1:0] NOP_INST = 32'h0400_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [WORD_LEN-1:0]    inst;
        logic [ADDRESS_LEN-1:0] pc1;
        logic                   valid;
    } ifid_t;

    // Empty pipeline slot: NOP with no associated pc.
    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.inst  = NOP_INST;
        b.pc1   = '0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with reset, flush (bubble insert) and hold.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   flush_i,
    input  logic [WORD_LEN-1:0]    inst_i,
    input  logic [ADDRESS_LEN-1:0] pc1_i,
    output ifid_t                  ifid_o
);

    ifid_t ifid_q;

    // Flush beats load; with neither asserted the register holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q <= ifid_bubble();
        end else if (flush_i) begin
            ifid_q <= ifid_bubble();
        end else if (load_i) begin
            ifid_q.inst  <= inst_i;
            ifid_q.pc1   <= pc1_i;
            ifid_q.valid <= 1'b1;
        end
    end

    assign ifid_o = ifid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, BOOT/RUN FSM and IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds saturating fetch/stall/flush counters.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   br_taken,
    input  logic [ADDRESS_LEN-1:0] br_adr,
    input  logic [WORD_LEN-1:0]    inst_in,
    output logic [ADDRESS_LEN-1:0] pc,
    output logic [WORD_LEN-1:0]    ifid_inst,
    output logic [ADDRESS_LEN-1:0] ifid_pc1,
    output logic                   ifid_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [CNT_LEN-1:0]     fetch_cnt,
    output logic [CNT_LEN-1:0]     stall_cnt,
    output logic [CNT_LEN-1:0]     flush_cnt
`endif
);

    if_state_e              state_q, state_d;
    logic [ADDRESS_LEN-1:0] pc_q, pc_d;
    logic [ADDRESS_LEN-1:0] pc_inc_c;
    logic                   load_c, flush_c;
    logic                   fetch_ev_c, stall_ev_c, flush_ev_c;
    ifid_t                  ifid;

    assign pc_inc_c = pc_q + ADDRESS_LEN'(1);

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and IF/ID control; redirect outranks freeze.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_c     = 1'b0;
        flush_c    = 1'b0;
        fetch_ev_c = 1'b0;
        stall_ev_c = 1'b0;
        flush_ev_c = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (br_taken) begin
                    pc_d    = br_adr;
                    flush_c = 1'b1;
                end
            end
            RUN: begin
                if (br_taken) begin
                    pc_d       = br_adr;
                    flush_c    = 1'b1;
                    flush_ev_c = 1'b1;
                end else if (freeze) begin
                    stall_ev_c = 1'b1;
                end else begin
                    pc_d       = pc_inc_c;
                    load_c     = 1'b1;
                    fetch_ev_c = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_c),
        .flush_i (flush_c),
        .inst_i  (inst_in),
        .pc1_i   (pc_inc_c),
        .ifid_o  (ifid)
    );

    assign pc         = pc_q;
    assign ifid_inst  = ifid.inst;
    assign ifid_pc1   = ifid.pc1;
    assign ifid_valid = ifid.valid;

`ifdef IF_PERF_CNT_EN
    logic [CNT_LEN-1:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

    // Saturating event counters, active only in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch_ev_c && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + CNT_LEN'(1);
            if (stall_ev_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_LEN'(1);
            if (flush_ev_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_LEN'(1);
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_ev_c;
    assign unused_ev_c = fetch_ev_c ^ stall_ev_c ^ flush_ev_c;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a combinational instruction-memory model.
module tb_if_stage;
    import if_stage_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   freeze;
    logic                   br_taken;
    logic [ADDRESS_LEN-1:0] br_adr;
    logic [WORD_LEN-1:0]    inst_in;
    logic [ADDRESS_LEN-1:0] pc;
    logic [WORD_LEN-1:0]    ifid_inst;
    logic [ADDRESS_LEN-1:0] ifid_pc1;
    logic                   ifid_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0]            fetch_cnt, stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .br_taken   (br_taken),
        .br_adr     (br_adr),
        .inst_in    (inst_in),
        .pc         (pc),
        .ifid_inst  (ifid_inst),
        .ifid_pc1   (ifid_pc1),
        .ifid_valid (ifid_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, never-NOP content per word address.
    function automatic logic [31:0] mem_f(input logic [7:0] a);
        return {8'hC3, a, 8'h5A, ~a};
    endfunction

    assign inst_in = mem_f(pc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] inst_e,
                            input logic [7:0] pc1_e, input logic v_e);
        chk({tag, "_inst"},  ifid_inst, inst_e);
        chk({tag, "_pc1"},   32'(ifid_pc1), 32'(pc1_e));
        chk({tag, "_valid"}, 32'(ifid_valid), 32'(v_e));
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_adr = '0;

        // Reset for two cycles, then BOOT and first fetch.
        tick(); tick();
        chk("rst_pc", 32'(pc), 32'd0);
        chk_ifid("rst", 32'h0400_0000, 8'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk("boot_pc", 32'(pc), 32'd0);
        chk_ifid("boot", 32'h0400_0000, 8'd0, 1'b0);
        tick();
        chk("first_pc", 32'(pc), 32'd1);
        chk_ifid("first", mem_f(8'd0), 8'd1, 1'b1);
        repeat (4) tick();
        chk("run5_pc", 32'(pc), 32'd5);
        chk_ifid("run5", mem_f(8'd4), 8'd5, 1'b1);

        // Reset while freeze and branch are pending discards both.
        rst = 1'b1; freeze = 1'b1; br_taken = 1'b1; br_adr = 8'd77;
        tick();
        rst = 1'b0; freeze = 1'b0; br_taken = 1'b0;
        chk("rst2_pc", 32'(pc), 32'd0);
        chk_ifid("rst2", 32'h0400_0000, 8'd0, 1'b0);
        tick();
        chk("boot2_pc", 32'(pc), 32'd0);
        tick(); tick(); tick();
        chk("pre_frz_pc", 32'(pc), 32'd3);
        chk_ifid("pre_frz", mem_f(8'd2), 8'd3, 1'b1);

        // Freeze holds everything for three cycles.
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_pc", 32'(pc), 32'd3);
            chk_ifid("frz", mem_f(8'd2), 8'd3, 1'b1);
        end
        freeze = 1'b0;
        tick();
        chk("resume_pc", 32'(pc), 32'd4);
        chk_ifid("resume", mem_f(8'd3), 8'd4, 1'b1);

        // Taken branch flushes, target fetched on the following edge.
        br_taken = 1'b1; br_adr = 8'd8;
        tick();
        chk("br8_pc", 32'(pc), 32'd8);
        chk_ifid("br8", 32'h0400_0000, 8'd0, 1'b0);
        br_taken = 1'b0;
        tick();
        chk("br8_next_pc", 32'(pc), 32'd9);
        chk_ifid("br8_next", mem_f(8'd8), 8'd9, 1'b1);

        // Branch beats freeze; back-to-back branches, last one wins.
        br_taken = 1'b1; freeze = 1'b1; br_adr = 8'd20;
        tick();
        chk("brfrz_pc", 32'(pc), 32'd20);
        chk_ifid("brfrz", 32'h0400_0000, 8'd0, 1'b0);
        freeze = 1'b0; br_adr = 8'd30;
        tick();
        chk("br30_pc", 32'(pc), 32'd30);
        br_adr = 8'd40;
        tick();
        chk("br40_pc", 32'(pc), 32'd40);
        chk_ifid("br40", 32'h0400_0000, 8'd0, 1'b0);
        br_taken = 1'b0;
        tick();
        chk("br40_next_pc", 32'(pc), 32'd41);
        chk_ifid("br40_next", mem_f(8'd40), 8'd41, 1'b1);

        // PC wrap at the top of the address space.
        br_taken = 1'b1; br_adr = 8'd254;
        tick();
        chk("br254_pc", 32'(pc), 32'd254);
        br_taken = 1'b0;
        tick();
        chk("w255_pc", 32'(pc), 32'd255);
        chk_ifid("w255", mem_f(8'd254), 8'd255, 1'b1);
        tick();
        chk("wrap_pc", 32'(pc), 32'd0);
        chk_ifid("wrap", mem_f(8'd255), 8'd0, 1'b1);
        tick();
        chk("wrap1_pc", 32'(pc), 32'd1);
        chk_ifid("wrap1", mem_f(8'd0), 8'd1, 1'b1);

        // Branch during BOOT redirects; then tally events for the counters.
        rst = 1'b1;
        tick();
        rst = 1'b0; br_taken = 1'b1; br_adr = 8'd50;
        tick();
        chk("bootbr_pc", 32'(pc), 32'd50);
        chk_ifid("bootbr", 32'h0400_0000, 8'd0, 1'b0);
        br_taken = 1'b0;
        tick();
        chk("bootbr_next_pc", 32'(pc), 32'd51);
        chk_ifid("bootbr_next", mem_f(8'd50), 8'd51, 1'b1);
        freeze = 1'b1;
        tick(); tick();
        chk("cnt_frz_pc", 32'(pc), 32'd51);
        freeze = 1'b0;
        tick();
        chk("cnt_run_pc", 32'(pc), 32'd52);
        chk_ifid("cnt_run", mem_f(8'd51), 8'd52, 1'b1);
        br_taken = 1'b1; br_adr = 8'd60;
        tick();
        br_taken = 1'b0;
        chk("cnt_br_pc", 32'(pc), 32'd60);
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, 32'd2);
        chk("stall_cnt", stall_cnt, 32'd2);
        chk("flush_cnt", flush_cnt, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: none; widths come from the shared configs (ADDRESS_LEN, WORD_LEN).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 freeze  input  1  hazard-unit stall; hold PC and IF/ID contents.
REQ-005 br_taken  input  1  branch resolved taken; redirect fetch.
REQ-006 br_adr  input  ADDRESS_LEN  branch target, word address.
REQ-007 inst_in  input  WORD_LEN  instruction from instruction memory, combinational on pc.
REQ-008 pc  output  ADDRESS_LEN  fetch address to instruction memory.
REQ-009 ifid_inst  output  WORD_LEN  registered instruction to decode.
REQ-010 ifid_pc1  output  ADDRESS_LEN  registered pc+1 of that instruction.
REQ-011 ifid_valid  output  1  IF/ID holds a real instruction.

Function
REQ-012 pc is a word address and increments by 1 per fetch; wraps modulo 2^ADDRESS_LEN with no error flag.
REQ-013 FSM states: BOOT (one cycle after reset, no fetch captured) and RUN; BOOT->RUN unconditionally next edge; RUN persists until rst.
REQ-014 In BOOT: pc holds 0, IF/ID holds NOP_INST, ifid_valid=0.
REQ-015 In RUN, no freeze, no br_taken: pc<=pc+1; ifid_inst<=inst_in; ifid_pc1<=pc+1; ifid_valid<=1.
REQ-016 freeze=1, br_taken=0: pc, ifid_inst, ifid_pc1, ifid_valid all hold.
REQ-017 br_taken=1 (freeze ignored): pc<=br_adr; ifid_inst<=NOP_INST; ifid_pc1<=0; ifid_valid<=0 (flush).
REQ-018 Priority: rst > br_taken > freeze > normal advance.
REQ-019 br_taken in BOOT: redirect takes effect (pc<=br_adr), state still goes to RUN.
REQ-020 Latency: instruction at address A appears on ifid_inst exactly one edge after pc=A is presented without freeze/redirect.
REQ-021 Consecutive br_taken cycles: each redirects; last one wins; IF/ID stays flushed.

Reset
REQ-022 On rst: state=BOOT, pc=0, ifid_inst=NOP_INST, ifid_pc1=0, ifid_valid=0, counters (if present)=0.
REQ-023 rst mid-stall or mid-redirect discards pending freeze/branch; first fetch after rst is address 0.

Configuration
REQ-024 Macro IF_PERF_CNT_EN: when defined, adds outputs fetch_cnt, stall_cnt, flush_cnt (32 bits each, saturating at all-ones) counting REQ-015, REQ-016, REQ-017 cycles respectively in RUN.
REQ-025 Without IF_PERF_CNT_EN: ports and counters absent; remaining behaviour identical.

Structure
REQ-026 NOP_INST (32'h0400_0000) and the FSM state encoding live in the shared configs file alongside ADDRESS_LEN/WORD_LEN.
REQ-027 One sub-module if_id_reg (IF/ID register with hold/flush/reset) is natural; PC logic and FSM stay in if_stage.

Verification
REQ-028 rst high 2 cycles, release -> BOOT cycle: pc=0, ifid_valid=0; next edge ifid_valid=1, ifid_inst=mem[0], ifid_pc1=1, pc=1.
REQ-029 Free run 5 cycles -> pc=5, ifid_inst=mem[4], ifid_pc1=5.
REQ-030 freeze high 3 cycles at pc=3 -> pc, ifid_inst=mem[2], ifid_pc1=3 unchanged for 3 cycles; resume -> pc=4.
REQ-031 br_taken with br_adr=8 at pc=4 -> next edge pc=8, ifid_valid=0, ifid_inst=NOP_INST; following edge ifid_inst=mem[8], ifid_pc1=9.
REQ-032 br_taken and freeze together, br_adr=20 -> redirect wins: pc=20, IF/ID flushed.
REQ-033 pc forced near 2^ADDRESS_LEN-1 via branch, free run -> pc wraps to 0; with IF_PERF_CNT_EN, fetch/stall/flush counts match cycle tallies.
